// File: rtl/sntrup_pkg.sv
// Shared definitions for the small-polynomial byte encoder.
//   SN_P / SN_AW / SN_DW : default coefficient count, memory address and data widths
//   state_t              : encoder FSM states
//   ENC_*                : 2-bit ternary codes (value + 1)
package sntrup_pkg;

  localparam int SN_P  = 677;
  localparam int SN_AW = 11;
  localparam int SN_DW = 13;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_EMIT,
    S_DONE
  } state_t;

  // A coefficient c in {-1,0,+1} is stored as the two LSBs of c+1.
  localparam logic [1:0] ENC_NEG  = 2'b00;
  localparam logic [1:0] ENC_ZERO = 2'b01;
  localparam logic [1:0] ENC_POS  = 2'b10;

endpackage

// File: rtl/small_pack4.sv
// Four-slot packer: collects 2-bit codes into one byte, slot 0 in bits [1:0].
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : empty the packer (slot and byte back to 0)
//   wr         : write code into the current slot
//   last       : this write closes the byte; slot returns to 0
//   code       : 2-bit ternary code
//   slot       : current slot index
//   pack       : packing register
//   pack_nxt   : packing register with code merged into the current slot
module small_pack4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       wr,
  input  logic       last,
  input  logic [1:0] code,
  output logic [1:0] slot,
  output logic [7:0] pack,
  output logic [7:0] pack_nxt
);

  always_comb begin
    pack_nxt = pack;
    pack_nxt[{slot, 1'b0} +: 2] = code;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot <= 2'd0;
      pack <= 8'd0;
    end else if (clr) begin
      slot <= 2'd0;
      pack <= 8'd0;
    end else if (wr) begin
      pack <= pack_nxt;
      slot <= last ? 2'd0 : slot + 2'd1;
    end
  end

endmodule

// File: rtl/small_encode.sv
// Reads P ternary coefficients from memory and streams them out packed four
// per byte (ready/valid), then pulses done.
//   clk, rst_n     : clock, synchronous active-low reset
//   start          : begin a run (IDLE only)
//   mem_address_o  : registered read address
//   mem_data       : read data, valid the cycle after the address changes
//   byte_o         : packed byte, byte_valid / byte_ready handshake
//   busy           : not IDLE
//   done           : one-cycle pulse after the final byte is taken
//   err            : sticky out-of-range coefficient flag, cleared on start
// Build option: SMALL_ENCODE_CHECK_EN enables the coefficient range check
// that drives err; otherwise err is constant 0.
module small_encode
  import sntrup_pkg::*;
#(
  parameter int P  = SN_P,
  parameter int AW = SN_AW,
  parameter int DW = SN_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] mem_address_o,
  input  logic [DW-1:0] mem_data,
  output logic [7:0]    byte_o,
  output logic          byte_valid,
  input  logic          byte_ready,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW-1:0] LAST_IDX = AW'(P - 1);
  localparam logic [AW-1:0] END_IDX  = AW'(P);

  state_t        state;
  logic [AW-1:0] idx;
  logic [1:0]    slot;
  logic [7:0]    pack;
  logic [7:0]    pack_nxt;
  logic [1:0]    code;
  logic          last;
  logic          kick;
  logic          xfer;

  // Two LSBs of c+1 only depend on the two LSBs of c.
  assign code = mem_data[1:0] + 2'd1;
  assign last = (slot == 2'd3) || (idx == LAST_IDX);
  assign kick = (state == S_IDLE) && start;
  assign xfer = (state == S_EMIT) && byte_ready;

  small_pack4 u_pack (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (kick || xfer),
    .wr       (state == S_LATCH),
    .last     (last),
    .code     (code),
    .slot     (slot),
    .pack     (pack),
    .pack_nxt (pack_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      idx           <= '0;
      mem_address_o <= '0;
      byte_o        <= 8'd0;
      byte_valid    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          mem_address_o <= idx;
          state         <= S_LATCH;
        end
        S_LATCH: begin
          idx <= idx + AW'(1);
          if (last) begin
            // byte_o is taken from the merged value so it is complete
            // the same cycle byte_valid rises.
            byte_o     <= pack_nxt;
            byte_valid <= 1'b1;
            state      <= S_EMIT;
          end else begin
            state <= S_FETCH;
          end
        end
        S_EMIT: begin
          if (byte_ready) begin
            byte_valid <= 1'b0;
            byte_o     <= 8'd0;
            if (idx == END_IDX) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SMALL_ENCODE_CHECK_EN
  logic coef_ok;
  assign coef_ok = (mem_data == '0) || (mem_data == DW'(1)) || (mem_data == {DW{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst_n)
      err <= 1'b0;
    else if (kick)
      err <= 1'b0;
    else if ((state == S_LATCH) && !coef_ok)
      err <= 1'b1;
  end
`else
  logic unused_hi;
  assign unused_hi = ^mem_data[DW-1:2];
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_small_encode.sv
module tb_small_encode;

  localparam int P  = 677;
  localparam int AW = 11;
  localparam int DW = 13;
  localparam int NB = (P + 3) / 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] mem_address_o;
  logic [DW-1:0] mem_data;
  logic [7:0]    byte_o;
  logic          byte_valid;
  logic          byte_ready;
  logic          busy;
  logic          done;
  logic          err;

  small_encode #(.P(P), .AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .mem_address_o (mem_address_o),
    .mem_data      (mem_data),
    .byte_o        (byte_o),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign mem_data = mem[mem_address_o];

  int         coef [P];
  logic [7:0] got [$];
  logic       errq [$];
  int         done_cnt;
  int         stall_n;
  int         checks   = 0;
  int         failures = 0;

`ifdef SMALL_ENCODE_CHECK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ternary value -> 2-bit code; the out-of-range value 2 maps to 3 (LSBs of 2+1).
  function automatic int enc(input int c);
    case (c)
      -1:      return 0;
      0:       return 1;
      1:       return 2;
      2:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] exp_byte(input int n);
    int v = 0;
    for (int m = 0; m < 4; m++)
      if (4*n + m < P) v += enc(coef[4*n + m]) * (4 ** m);
    return 8'(v);
  endfunction

  task automatic load_mem();
    for (int i = 0; i < P; i++) mem[i] = DW'(coef[i]);
  endtask

  // rmode: 0 ready always high, 1 stall byte 3 for 5 cycles, 2 random ready.
  // rst_byte >= 0: pulse reset once that many bytes have been taken.
  task automatic run_enc(input int rmode, input int rst_byte);
    bit         fin     = 0;
    bit         stalled = 0;
    bit         rdy;
    bit         act;
    logic [7:0] held    = 8'd0;
    got.delete();
    errq.delete();
    done_cnt = 0;
    stall_n  = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int cyc = 0; cyc < 10000 && !fin; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        chk("hold_valid", byte_valid, 1);
        chk("hold_byte", byte_o, held);
      end
      if (done) begin
        done_cnt++;
        chk("done_after_last", got.size(), NB);
      end
      if (!busy && !done) fin = 1;
      if (rst_byte >= 0 && got.size() == rst_byte) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", byte_valid, 0);
        chk("rst_byte", byte_o, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", mem_address_o, 0);
        act = 0;
        repeat (20) begin
          @(negedge clk);
          if (done || byte_valid || busy) act = 1;
        end
        chk("quiet_after_rst", act, 0);
        fin = 1;
      end else begin
        rdy = 1;
        if (rmode == 1 && byte_valid && got.size() == 3 && stall_n < 5) begin
          rdy = 0;
          stall_n++;
        end else if (rmode == 2) begin
          rdy = bit'($urandom_range(0, 1));
        end
        byte_ready = rdy;
        if (byte_valid && rdy) begin
          got.push_back(byte_o);
          errq.push_back(err);
        end
        stalled = byte_valid && !rdy;
        held    = byte_o;
      end
    end
    chk("run_terminated", fin, 1);
  endtask

  task automatic compare_all(input string name);
    chk({name, "_count"}, got.size(), NB);
    chk({name, "_done"}, done_cnt, 1);
    for (int i = 0; i < NB && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), got[i], exp_byte(i));
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_ready = 1'b1;
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_valid", byte_valid, 0);
    chk("reset_byte", byte_o, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_addr", mem_address_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // all zero
    for (int i = 0; i < P; i++) coef[i] = 0;
    load_mem();
    run_enc(0, -1);
    compare_all("zero");
    if (got.size() == NB) begin
      chk("zero_first", got[0], 8'h55);
      chk("zero_last", got[NB-1], 8'h01);
    end

    // all +1
    for (int i = 0; i < P; i++) coef[i] = 1;
    load_mem();
    run_enc(0, -1);
    compare_all("pos");
    if (got.size() == NB) chk("pos_last", got[NB-1], 8'h02);

    // all -1
    for (int i = 0; i < P; i++) coef[i] = -1;
    load_mem();
    run_enc(0, -1);
    compare_all("neg");

    // -1,0,+1,0 repeating
    for (int i = 0; i < P; i++) coef[i] = (i % 4 == 0) ? -1 : (i % 4 == 2) ? 1 : 0;
    load_mem();
    run_enc(0, -1);
    compare_all("pat");
    if (got.size() == NB) begin
      chk("pat_first", got[0], 8'h64);
      chk("pat_last", got[NB-1], 8'h00);
    end

    // random coefficients, stall during byte 3
    for (int i = 0; i < P; i++) coef[i] = int'($urandom_range(0, 2)) - 1;
    load_mem();
    run_enc(1, -1);
    compare_all("stall");
    chk("stall_cycles", stall_n, 5);

    // reset at byte 50, then a full re-encode with random ready
    for (int i = 0; i < P; i++) coef[i] = int'($urandom_range(0, 2)) - 1;
    load_mem();
    run_enc(2, 50);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_bytes", got.size(), 50);
    run_enc(2, -1);
    compare_all("rerun");

    // out-of-range coefficient at index 10
    for (int i = 0; i < P; i++) coef[i] = 0;
    coef[10] = 2;
    load_mem();
    run_enc(0, -1);
    compare_all("bad");
    if (got.size() == NB) begin
      chk("bad_byte2", got[2], 8'h75);
      chk("bad_err_b1", errq[1], 0);
      chk("bad_err_b2", errq[2], CHK_EN);
      chk("bad_err_last", errq[NB-1], CHK_EN);
    end
    chk("bad_err_sticky", err, CHK_EN);

    // next start clears err
    for (int i = 0; i < P; i++) coef[i] = 1;
    load_mem();
    run_enc(0, -1);
    compare_all("clr");
    chk("err_cleared", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/small_encode.md
SMALL_ENCODE -- requirements
Module: small_encode

Interface
REQ-001 Parameter P, default 677: number of ternary coefficients read per run.
REQ-002 Parameter AW, default 11: memory address width.
REQ-003 Parameter DW, default 13: memory data width; each coefficient is a DW-bit two's-complement value in {-1,0,+1}.
REQ-004 clk  in  1  single clock; every register updates on the rising edge only.
REQ-005 rst_n  in  1  synchronous, active-low reset, sampled on the rising clk edge.
REQ-006 start  in  1  one-cycle request to encode the stored polynomial; ignored unless in IDLE.
REQ-007 mem_address_o  out  AW  coefficient-memory read address, registered.
REQ-008 mem_data  in  DW  read data; valid exactly one cycle after mem_address_o changes.
REQ-009 byte_o  out  8  packed output byte.
REQ-010 byte_valid  out  1  byte_o holds a valid byte.
REQ-011 byte_ready  in  1  downstream accepts byte_o.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse after the last byte is accepted.
REQ-014 err  out  1  sticky flag: an out-of-range coefficient was seen; cleared on start.

Function
REQ-015 FSM states: IDLE, FETCH, LATCH, EMIT, DONE.
REQ-016 IDLE + start: idx<=0, slot<=0, packing register<=0, err<=0, go FETCH.
REQ-017 FETCH: mem_address_o<=idx; go LATCH.
REQ-018 LATCH: sample mem_data as c; write the two LSBs of (c+1) into packing bits [2*slot+1:2*slot]; idx<=idx+1.
REQ-019 LATCH exit: if slot==3 or idx==P-1, go EMIT and reset slot to 0; otherwise slot<=slot+1 and go FETCH.
REQ-020 Encoding: -1->2'b00, 0->2'b01, +1->2'b10; coefficient 4n+m occupies bits [2m+1:2m] of byte n.
REQ-021 EMIT: byte_valid=1 and byte_o=packing register; both stay stable until byte_ready is high on a clk edge.
REQ-022 A byte is transferred on a cycle with byte_valid&&byte_ready. After the transfer: packing register<=0; go DONE if idx==P, else go FETCH.
REQ-023 Byte count is ceil(P/4), i.e. 170 for P=677. The final byte holds coefficient 676 in bits [1:0]; bits [7:2]=0.
REQ-024 DONE: done=1 for exactly one cycle, then go IDLE.
REQ-025 byte_ready outside EMIT has no effect. start outside IDLE has no effect.
REQ-026 idx is an AW-bit counter and never wraps within a run (P-1 < 2^AW).

Reset
REQ-027 rst_n low: state<=IDLE; idx, slot, packing register, mem_address_o, byte_o<=0; byte_valid, busy, done, err<=0.
REQ-028 Reset mid-run aborts immediately: no further bytes and no done pulse.

Configuration
REQ-029 Macro SMALL_ENCODE_CHECK_EN:
 - Defined: in LATCH, any c not in {0, 1, 2^DW-1} sets err; encoding of that coefficient still uses the two LSBs of (c+1).
 - Undefined: err is tied to 0 and no check logic is built.

Structure
REQ-030 Package sntrup_pkg holds P, AW, DW, the FSM state enum, and the 2-bit ternary encoding constants.
REQ-031 One sub-module, small_pack4, is natural: it owns the slot counter and the packing register.

Verification
REQ-032 All 677 coefficients 0, byte_ready=1 -> 169 bytes of 0x55, then 0x01, then one done pulse.
REQ-033 All coefficients +1 -> 169 bytes of 0xAA, last byte 0x02. All coefficients -1 -> 170 bytes of 0x00.
REQ-034 Repeating pattern -1,0,+1,0 -> bytes 0x64. The last coefficient is 676 (676 mod 4 = 0), so it is -1 and the last byte is 0x00.
REQ-035 byte_ready held low for 5 cycles during EMIT of byte 3 -> byte_o and byte_valid stable throughout; no coefficient lost; total still 170 bytes.
REQ-036 rst_n low for 1 cycle at byte 50 -> IDLE next cycle with all outputs 0 and no done. A following start re-encodes from idx 0.
REQ-037 With SMALL_ENCODE_CHECK_EN, coefficient 10 = 13'h0002 -> err=1 from LATCH of idx 10 until the next start; byte 2 = 0x55 with bits [5:4]=2'b11.
